addsub_seq: RTL
===============

# addsub_seq

Parametrised, chunk-serial two's-complement adder/subtractor with valid/ready handshakes, signed-overflow detection and optional saturation. It processes a WIDTH-bit operation CHUNK bits per clock, reusing one narrow ripple adder, and serves as the shared arithmetic unit for wide operands where area matters more than latency. Only one operation is in flight at a time.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; ≥2.
- CHUNK, 4, bits added per cycle; must divide WIDTH exactly. Elaboration error otherwise.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE and not in reset.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- m  in  1  mode: 0 = a+b, 1 = a−b.
- sat  in  1  1 = saturate sum on signed overflow.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of MSB (for subtract, 1 = no borrow).
- v  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- NCH = WIDTH/CHUNK. States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b XOR {WIDTH{m}}, sat, a[WIDTH-1]; carry register = m; chunk counter = 0; go to RUN.
- RUN: each cycle add chunk[cnt] of the latched operands plus the carry register. Write the CHUNK result bits to sum bits [cnt*CHUNK +: CHUNK]. Update carry. Increment cnt. On cnt==NCH-1, capture carry into MSB and carry out, then go to DONE.
- DONE: out_valid=1. sum/cout/v are stable and held until out_valid&out_ready, then go to IDLE.
- Saturation: if the latched sat=1 and v=1, sum = 0 followed by all ones (max positive) when the latched a[MSB]=0, else 1 followed by all zeros (min negative). cout and v always report raw values.
- Inputs are ignored outside IDLE. Changes to a/b/m/sat after accept have no effect.
- CHUNK==WIDTH is legal: NCH=1, a single RUN cycle.

## Timing
- Reset values: state IDLE, in_ready=0 while rst is high, out_valid=0, sum=0, cout=0, v=0, counter=0. in_ready=1 in the first cycle after rst deasserts.
- Latency: the accept edge is E0. RUN occupies edges E1..E_NCH. out_valid goes high after E_NCH.
- Minimum issue interval: NCH+2 cycles (one DONE cycle, then one IDLE cycle) with out_ready held high.
- out_valid is registered. in_ready is decoded from state only, with no combinational path from in_valid or out_ready.
- Reset mid-RUN or mid-DONE: the operation is aborted, no out_valid is produced, and all outputs return to their reset values on that edge.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. The request is accepted no earlier than the following IDLE cycle.

## Structure
- Shared package addsub_pkg: state enum (IDLE, RUN, DONE), a helper function computing NCH, and saturation constants as functions of WIDTH.
- One sub-module, chunk_adder: a CHUNK-bit ripple adder built from the existing full_adder cell. Inputs: a, b, cin. Outputs: s, cout, cmsb (carry into its top bit).
- Top level contains the FSM, counter, operand registers, result register and saturation mux.

## Test plan
All with WIDTH=16, CHUNK=4 unless noted.
- 0x1234+0x0001, m=0: sum=0x1235, cout=0, v=0; out_valid exactly 4 cycles after the accept edge.
- 0x0005−0x0007, m=1: sum=0xFFFE, cout=0, v=0. Then 0x0007−0x0005: sum=0x0002, cout=1, v=0.
- 0x7FFF+0x0001: with sat=0, sum=0x8000, v=1, cout=0; with sat=1, sum=0x7FFF, v=1, cout=0.
- 0x8000−0x0001, sat=1: sum=0x8000, v=1, cout=1. With sat=0: sum=0x7FFF.
- Backpressure: out_ready low for 5 cycles in DONE while in_valid pulses with new operands. Required: sum/cout/v/out_valid stable, in_ready=0, new operands ignored. After the handshake, in_ready=1 on the next cycle.
- Reset at the second RUN cycle: out_valid never asserts, outputs are 0, and a new operation after release completes correctly. Repeat with CHUNK=16: out_valid 1 cycle after accept.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the chunk-serial adder/subtractor.
// Saturation limits are built as wide vectors and sliced to WIDTH by users.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int MAXW = 64;

    function automatic int nch(input int w, input int c);
        return w / c;
    endfunction

    function automatic logic [MAXW-1:0] sat_pos(input int w);
        return (MAXW'(1) << (w - 1)) - MAXW'(1);
    endfunction

    function automatic logic [MAXW-1:0] sat_neg(input int w);
        return MAXW'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/addsub_seq_chunk_adder.sv
// CHUNK-bit ripple adder; cmsb is the carry into the top bit, used for
// signed overflow on the final chunk.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_seq.sv
// Chunk-serial two's-complement add/subtract with valid/ready handshakes,
// signed-overflow flag and optional saturation.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             v
);

    localparam int N = nch(WIDTH, CHUNK);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [MAXW-1:0] POSW = sat_pos(WIDTH);
    localparam logic [MAXW-1:0] NEGW = sat_neg(WIDTH);

    if (WIDTH < 2 || WIDTH > MAXW || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad
        $error("addsub_seq: illegal WIDTH/CHUNK combination");
    end

    state_t state, nstate;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ra, rb, rsum;
    logic             rsat, rsign, carry, rcout, rv, ov;
    logic [CHUNK-1:0] cs;
    logic             cco, ccm;
    logic             accept;

    assign in_ready = (state == IDLE) & ~rst;
    assign accept   = in_valid & in_ready;

    chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a    (ra[cnt*CHUNK +: CHUNK]),
        .b    (rb[cnt*CHUNK +: CHUNK]),
        .cin  (carry),
        .s    (cs),
        .cout (cco),
        .cmsb (ccm)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (accept) nstate = RUN;
            RUN:     if (cnt == LAST) nstate = DONE;
            DONE:    if (out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            ra    <= '0;
            rb    <= '0;
            rsum  <= '0;
            rsat  <= 1'b0;
            rsign <= 1'b0;
            carry <= 1'b0;
            rcout <= 1'b0;
            rv    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            if (accept) begin
                ra    <= a;
                rb    <= b ^ {WIDTH{m}};
                rsat  <= sat;
                rsign <= a[WIDTH-1];
                carry <= m;
                cnt   <= '0;
                rsum  <= '0;
                rcout <= 1'b0;
                rv    <= 1'b0;
            end
            if (state == RUN) begin
                rsum[cnt*CHUNK +: CHUNK] <= cs;
                carry <= cco;
                cnt   <= cnt + CW'(1);
                if (cnt == LAST) begin
                    rcout <= cco;
                    rv    <= ccm ^ cco;
                    ov    <= 1'b1;
                    cnt   <= '0;
                end
            end
            if (ov && out_ready) ov <= 1'b0;
        end
    end

    // Saturation direction follows the sign of the latched A operand.
    assign sum = (rsat & rv) ? (rsign ? NEGW[WIDTH-1:0] : POSW[WIDTH-1:0]) : rsum;

    assign out_valid = ov;
    assign cout      = rcout;
    assign v         = rv;

endmodule
